regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The module SHALL have parameter LD_DEPTH, default 4, giving the load-queue depth in entries (power of two, 2..8).
REQ-002 The module SHALL have parameter DATA_W, default 16, giving the register data width.
REQ-003 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have the port clr, input, 1 bit: asynchronous active-low reset; the low level clears state immediately.
REQ-005 The module SHALL have the port alu_valid, input, 1 bit: an ALU result write is requested this cycle.
REQ-006 The module SHALL have the port alu_addr, input, 4 bits: the ALU destination register index.
REQ-007 The module SHALL have the port alu_data, input, DATA_W bits: the ALU result.
REQ-008 The module SHALL have the port ld_valid, input, 1 bit: a memory-load write is offered.
REQ-009 The module SHALL have the port ld_ready, output, 1 bit: the load queue accepts the offer this cycle.
REQ-010 The module SHALL have the port ld_addr, input, 4 bits: the load destination register index.
REQ-011 The module SHALL have the port ld_data, input, DATA_W bits: the load data.
REQ-012 The module SHALL have the port reg_en, output, 16 bits: the one-hot per-register write enable driving the 16-entry register file.
REQ-013 The module SHALL have the port wr_data, output, DATA_W bits: the data bus shared by all registers.
REQ-014 The module SHALL have the port pending, output, 16 bits: bit i is set while any queued load targets register i.
REQ-015 The module SHALL have the port ld_count, output, 4 bits: the number of valid queue entries.
REQ-016 The module SHALL have the port collision, output, 1 bit: sticky flag for an ALU write to a pending register.

Function
REQ-017 The ALU path SHALL have no backpressure; every cycle with alu_valid=1 SHALL produce a write.
REQ-018 A load SHALL be pushed on a clock edge when ld_valid=1 and ld_ready=1.
REQ-019 ld_ready SHALL equal (ld_count < LD_DEPTH); a pop in the same cycle SHALL NOT raise ld_ready while the queue is full.
REQ-020 Write-port arbitration SHALL be fixed priority: ALU first, then the queue head; the head SHALL pop only in a cycle with alu_valid=0 and ld_count>0.
REQ-021 The selected write SHALL appear on the next edge: reg_en=onehot(addr) and wr_data=data, held for exactly one cycle.
REQ-022 In cycles with no selected write, reg_en SHALL be 0 and wr_data SHALL hold its last value.
REQ-023 reg_en SHALL never have more than one bit set.
REQ-024 Latency SHALL be 1 cycle from ALU request to reg_en; the minimum load latency SHALL be 2 cycles, push to reg_en.
REQ-025 The queue SHALL be strict FIFO; read and write pointers SHALL wrap modulo LD_DEPTH.
REQ-026 A push and a pop in the same cycle SHALL leave ld_count unchanged.
REQ-027 pending SHALL be the combinational OR of onehot(addr) over the valid entries; with duplicates, a bit SHALL stay set until the last matching entry pops.
REQ-028 If alu_valid=1 and pending[alu_addr]=1, the ALU write SHALL still proceed, and collision SHALL set on the next edge and stay set until reset.
REQ-029 A load pushed while the queue is empty and alu_valid=0 SHALL NOT bypass the queue.

Reset
REQ-030 While clr=0, the module SHALL hold reg_en=0, wr_data=0, ld_count=0, pending=0, collision=0, ld_ready=0, and both pointers at 0.
REQ-031 ld_ready SHALL be 1 in the first cycle after clr rises.
REQ-032 A reset during operation SHALL discard queued loads without emitting any reg_en pulse.

Structure
REQ-033 Shared package regfile_pkg SHALL hold NUM_REGS=16, ADDR_W=4, REG_W=16, and a onehot16 decode function.
REQ-034 The load queue SHALL be the sub-module wb_fifo, with push/pop/full/empty/count and per-entry valid/addr visible for the pending computation.

Verification
REQ-035 The bench SHALL cover: ALU write with alu_addr=5 and alu_data=0x1234 -> next cycle reg_en=0x0020, wr_data=0x1234; the following cycle reg_en=0.
REQ-036 The bench SHALL cover: load with ld_addr=3 and ld_data=0xBEEF while the ALU is idle -> pending=0x0008 after the push; reg_en=0x0008 and wr_data=0xBEEF 2 cycles after the push; then pending=0.
REQ-037 The bench SHALL cover: 4 loads pushed while alu_valid is held at 1 -> ld_count=4, ld_ready=0, a 5th offer not accepted; when the ALU is released, the loads drain in order, one per cycle.
REQ-038 The bench SHALL cover: a queued load to reg 7 plus an ALU write to reg 7 -> the ALU write is emitted first, collision=1, then the load to reg 7 is emitted.
REQ-039 The bench SHALL cover: clr pulsed low with 3 loads queued -> immediately reg_en=0 and ld_count=0; no reg_en pulse afterwards; ld_ready=1 one cycle after release.
REQ-040 The bench SHALL cover: push and pop in the same cycle at ld_count=2 -> ld_count stays 2, and the pointers wrap correctly over 10 such cycles.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared register-file constants and the address-to-enable decode.
package regfile_pkg;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int REG_W    = 16;

    function automatic logic [NUM_REGS-1:0] onehot16(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/regfile_writeback_if.sv
// Write-back bus: ALU and load request sides plus register-file write port and status.
interface regfile_writeback_if #(parameter int DATA_W = 16);
    import regfile_pkg::*;

    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_addr;
    logic [DATA_W-1:0]   alu_data;
    logic                ld_valid;
    logic                ld_ready;
    logic [ADDR_W-1:0]   ld_addr;
    logic [DATA_W-1:0]   ld_data;
    logic [NUM_REGS-1:0] reg_en;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] pending;
    logic [3:0]          ld_count;
    logic                collision;

    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        input  ld_ready, reg_en, wr_data, pending, ld_count, collision
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        output ld_ready, reg_en, wr_data, pending, ld_count, collision
    );
endinterface

// File: rtl/regfile_writeback_fifo.sv
// Load queue: strict FIFO whose per-entry valid/address are exported for hazard tracking.
module wb_fifo import regfile_pkg::*; #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          push,
    input  logic                          pop,
    input  logic [ADDR_W-1:0]             pushAddr,
    input  logic [DATA_W-1:0]             pushData,
    output logic                          full,
    output logic                          empty,
    output logic [3:0]                    count,
    output logic [ADDR_W-1:0]             headAddr,
    output logic [DATA_W-1:0]             headData,
    output logic [DEPTH-1:0]              entVld,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entAddr
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [PW-1:0]     wrPtr, rdPtr;
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic              doPush, doPop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == 4'd0);
    assign doPush   = push & ~full;
    assign doPop    = pop & ~empty;
    assign headAddr = entAddr[rdPtr];
    assign headData = dataMem[rdPtr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            entVld  <= '0;
            entAddr <= '0;
        end else begin
            if (doPush) begin
                entVld[wrPtr]  <= 1'b1;
                entAddr[wrPtr] <= pushAddr;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (doPop) begin
                entVld[rdPtr] <= 1'b0;
                rdPtr         <= rdPtr + 1'b1;
            end
            count <= count + {3'b0, doPush} - {3'b0, doPop};
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) dataMem[wrPtr] <= pushData;
    end
endmodule

// File: rtl/regfile_writeback.sv
// Write-back arbiter: ALU results win the single register-file port, queued loads fill idle cycles.
module regfile_writeback import regfile_pkg::*; #(
    parameter int LD_DEPTH = 4,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                clr,
    regfile_writeback_if.slave  bus
);
    logic                          push, pop, full, empty;
    logic [3:0]                    count;
    logic [ADDR_W-1:0]             headAddr;
    logic [DATA_W-1:0]             headData;
    logic [LD_DEPTH-1:0]           entVld;
    logic [LD_DEPTH-1:0][ADDR_W-1:0] entAddr;
    logic [NUM_REGS-1:0]           pendingVec;
    logic [NUM_REGS-1:0]           regEn;
    logic [DATA_W-1:0]             wrData;
    logic                          collision;

    // Gating with clr keeps the queue closed while reset is held.
    assign bus.ld_ready = clr & ~full;
    assign push         = bus.ld_valid & bus.ld_ready;
    assign pop          = ~bus.alu_valid & ~empty;

    wb_fifo #(.DEPTH(LD_DEPTH), .DATA_W(DATA_W)) uFifo (
        .clk      (clk),
        .clr      (clr),
        .push     (push),
        .pop      (pop),
        .pushAddr (bus.ld_addr),
        .pushData (bus.ld_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .headAddr (headAddr),
        .headData (headData),
        .entVld   (entVld),
        .entAddr  (entAddr)
    );

    always_comb begin
        pendingVec = '0;
        for (int i = 0; i < LD_DEPTH; i++)
            if (entVld[i]) pendingVec = pendingVec | onehot16(entAddr[i]);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            regEn     <= '0;
            wrData    <= '0;
            collision <= 1'b0;
        end else begin
            regEn <= '0;
            if (bus.alu_valid) begin
                regEn  <= onehot16(bus.alu_addr);
                wrData <= bus.alu_data;
                if (pendingVec[bus.alu_addr]) collision <= 1'b1;
            end else if (!empty) begin
                regEn  <= onehot16(headAddr);
                wrData <= headData;
            end
        end
    end

    assign bus.reg_en    = regEn;
    assign bus.wr_data   = wrData;
    assign bus.pending   = pendingVec;
    assign bus.ld_count  = count;
    assign bus.collision = collision;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and randomized checks of regfile_writeback against a queue-based model.
module tb_regfile_writeback;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   nCmp = 0;
    int   nBad = 0;

    ent_t        mq[$];
    logic [15:0] expEn   = '0;
    logic [15:0] expData = '0;
    logic        expColl = 1'b0;

    regfile_writeback_if #(.DATA_W(16)) bus();

    regfile_writeback #(.LD_DEPTH(DEPTH), .DATA_W(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] modelPending();
        logic [15:0] p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        return p;
    endfunction

    // One clock: drive, check status before the edge, advance model, check outputs after it.
    task automatic cycle(input bit av, input logic [3:0] aa, input logic [15:0] ad,
                         input bit lv, input logic [3:0] la, input logic [15:0] lData);
        bit   rdy;
        ent_t e;
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.ld_valid  = lv; bus.ld_addr  = la; bus.ld_data  = lData;
        #1;
        rdy = (mq.size() < DEPTH);
        chk("ld_ready", 32'(bus.ld_ready), 32'(rdy));
        chk("ld_count", 32'(bus.ld_count), 32'(mq.size()));
        chk("pending",  32'(bus.pending),  32'(modelPending()));
        if (av) begin
            expEn   = 16'(1) << aa;
            expData = ad;
            foreach (mq[i]) if (mq[i].a == aa) expColl = 1'b1;
        end else if (mq.size() > 0) begin
            e       = mq.pop_front();
            expEn   = 16'(1) << e.a;
            expData = e.d;
        end else begin
            expEn = '0;
        end
        if (lv && rdy) mq.push_back('{a: la, d: lData});
        @(posedge clk); #1;
        chk("reg_en",    32'(bus.reg_en),    32'(expEn));
        chk("wr_data",   32'(bus.wr_data),   32'(expData));
        chk("collision", 32'(bus.collision), 32'(expColl));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
    endtask

    initial begin
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.ld_valid  = 0; bus.ld_addr  = 0; bus.ld_data  = 0;

        // Power-on reset state
        #2;
        chk("rst reg_en",    32'(bus.reg_en),    32'h0);
        chk("rst wr_data",   32'(bus.wr_data),   32'h0);
        chk("rst ld_count",  32'(bus.ld_count),  32'h0);
        chk("rst pending",   32'(bus.pending),   32'h0);
        chk("rst collision", 32'(bus.collision), 32'h0);
        chk("rst ld_ready",  32'(bus.ld_ready),  32'h0);
        @(posedge clk); #2;
        clr = 1'b1; #1;
        chk("ready after clr", 32'(bus.ld_ready), 32'h1);
        @(posedge clk); #1;

        // ALU write to reg 5
        cycle(1, 4'd5, 16'h1234, 0, 4'd0, 16'd0);
        chk("alu reg_en",  32'(bus.reg_en),  32'h0020);
        chk("alu wr_data", 32'(bus.wr_data), 32'h1234);
        cycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
        chk("alu reg_en clear", 32'(bus.reg_en),  32'h0);
        chk("wr_data holds",    32'(bus.wr_data), 32'h1234);

        // Single load to reg 3, no bypass
        cycle(0, 4'd0, 16'd0, 1, 4'd3, 16'hBEEF);
        chk("ld no bypass", 32'(bus.reg_en),  32'h0);
        chk("ld pending",   32'(bus.pending), 32'h0008);
        cycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
        chk("ld reg_en",    32'(bus.reg_en),  32'h0008);
        chk("ld wr_data",   32'(bus.wr_data), 32'hBEEF);
        chk("ld pend clr",  32'(bus.pending), 32'h0);

        // Fill queue under ALU pressure, fifth offer refused, then drain in order
        for (int i = 0; i < 4; i++)
            cycle(1, 4'(i), 16'(16'h100 + i), 1, 4'(8 + i), 16'(16'hA000 + i));
        chk("full count", 32'(bus.ld_count), 32'h4);
        chk("full ready", 32'(bus.ld_ready), 32'h0);
        cycle(1, 4'd1, 16'h0111, 1, 4'd15, 16'hDEAD);
        chk("5th refused", 32'(bus.ld_count), 32'h4);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
            chk("drain order", 32'(bus.wr_data), 32'(16'hA000 + i));
        end
        idle(1);

        // Collision on reg 7: ALU goes first, then the queued load
        cycle(1, 4'd2, 16'h2222, 1, 4'd7, 16'h7777);
        cycle(1, 4'd7, 16'h7A7A, 0, 4'd0, 16'd0);
        chk("coll alu first", 32'(bus.reg_en),    32'h0080);
        chk("coll flag",      32'(bus.collision), 32'h1);
        cycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0);
        chk("coll load data", 32'(bus.wr_data),   32'h7777);
        idle(2);

        // Reset with 3 loads queued
        for (int i = 0; i < 3; i++)
            cycle(1, 4'd0, 16'h0, 1, 4'(i + 1), 16'(16'hC000 + i));
        bus.alu_valid = 0; bus.ld_valid = 0;
        clr = 1'b0; #1;
        mq.delete(); expEn = '0; expData = '0; expColl = 1'b0;
        chk("midrst reg_en",   32'(bus.reg_en),   32'h0);
        chk("midrst count",    32'(bus.ld_count), 32'h0);
        chk("midrst pending",  32'(bus.pending),  32'h0);
        chk("midrst coll",     32'(bus.collision),32'h0);
        @(posedge clk); #1;
        chk("midrst hold",     32'(bus.reg_en),   32'h0);
        #1 clr = 1'b1; #1;
        chk("midrst ready",    32'(bus.ld_ready), 32'h1);
        @(posedge clk); #1;
        idle(4);

        // Simultaneous push/pop at depth 2 across pointer wrap
        cycle(1, 4'd9, 16'h0909, 1, 4'd4, 16'hD000);
        cycle(1, 4'd9, 16'h0909, 1, 4'd5, 16'hD001);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 4'd0, 16'd0, 1, 4'(i + 6), 16'(16'hD002 + i));
            chk("pp count", 32'(bus.ld_count), 32'h2);
            chk("pp data",  32'(bus.wr_data),  32'(16'hD000 + i));
        end
        idle(3);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 4, 4'($urandom), 16'($urandom),
                  $urandom_range(0, 9) < 6, 4'($urandom), 16'($urandom));
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
